// File: rtl/and_masking_pkg.sv
// Shared types and helpers for the 2-share masked AND feeder.
package and_masking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RND,
    DRIVE,
    PRECH
  } feeder_state_e;

  // Index of each share inside the packed share register.
  localparam int unsigned ShareA0   = 0;
  localparam int unsigned ShareA1   = 1;
  localparam int unsigned ShareB0   = 2;
  localparam int unsigned ShareB1   = 3;
  localparam int unsigned NumShares = 4;

  // Width of a counter that indexes the HOLD cycles of DRIVE (at least 1 bit).
  function automatic int unsigned calc_hold_cnt_width(input int unsigned hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/mask_rnd_cache.sv
// Mask cache for the masked AND feeder: holds m1/m2 from one RNG word and a valid flag.
// Optional feature macro: FEEDER_MASK_REUSE_EN (one RNG word serves REUSE_MAX ops).
module mask_rnd_cache #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned REUSE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [2*WIDTH-1:0] rnd_word,
  input  logic               consume,
  input  logic               flush,
  output logic [WIDTH-1:0]   m1,
  output logic [WIDTH-1:0]   m2,
  output logic               valid
);

  if (REUSE_MAX == 0) begin : g_bad_reuse
    $error("REUSE_MAX must be at least 1");
  end

  logic [WIDTH-1:0] m1_q, m1_d, m2_q, m2_d;
  logic             valid_q, valid_d;

`ifdef FEEDER_MASK_REUSE_EN
  localparam int unsigned CntW = $clog2(REUSE_MAX + 1);
  localparam logic [CntW-1:0] ReuseLast = CntW'(REUSE_MAX - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  // Next-state: load on RNG handshake, invalidate after the op(s) the word may serve.
  always_comb begin
    m1_d    = m1_q;
    m2_d    = m2_q;
    valid_d = valid_q;
`ifdef FEEDER_MASK_REUSE_EN
    cnt_d   = cnt_q;
`endif
    if (load) begin
      m1_d    = rnd_word[WIDTH-1:0];
      m2_d    = rnd_word[2*WIDTH-1:WIDTH];
      valid_d = 1'b1;
    end
`ifdef FEEDER_MASK_REUSE_EN
    if (consume) begin
      if (cnt_q == ReuseLast) begin
        valid_d = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (flush) begin
      valid_d = 1'b0;
      cnt_d   = '0;
    end
`else
    if (consume || flush) begin
      valid_d = 1'b0;
    end
`endif
    // Spent masks are wiped so they never linger in the register.
    if (!valid_d) begin
      m1_d = '0;
      m2_d = '0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      m1_q    <= '0;
      m2_q    <= '0;
      valid_q <= 1'b0;
`ifdef FEEDER_MASK_REUSE_EN
      cnt_q   <= '0;
`endif
    end else begin
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      valid_q <= valid_d;
`ifdef FEEDER_MASK_REUSE_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign m1    = m1_q;
  assign m2    = m2_q;
  assign valid = valid_q;

endmodule

// File: rtl/masked_and_feeder.sv
// Upstream feeder of the 2-share masked AND gate: masks operands, drives shares for HOLD
// cycles, precharges to zero and strobes res_valid when the gate result is valid.
// Optional feature macro: FEEDER_MASK_REUSE_EN (handled inside mask_rnd_cache).
module masked_and_feeder
  import and_masking_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned GATE_LAT  = 2,
  parameter int unsigned HOLD      = 2,
  parameter int unsigned REUSE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               rnd_valid,
  output logic               rnd_ready,
  input  logic [2*WIDTH-1:0] rnd_data,
  output logic [WIDTH-1:0]   a0,
  output logic [WIDTH-1:0]   a1,
  output logic [WIDTH-1:0]   b0,
  output logic [WIDTH-1:0]   b1,
  output logic [WIDTH-1:0]   mask_or,
  output logic               share_vld,
  output logic               res_valid
);

  if (HOLD < GATE_LAT) begin : g_bad_hold
    $error("HOLD must be >= GATE_LAT");
  end
  if (GATE_LAT == 0) begin : g_bad_lat
    $error("GATE_LAT must be at least 1");
  end

  localparam int unsigned CntW = calc_hold_cnt_width(HOLD);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD - 1);
  localparam logic [CntW-1:0] GateLast = CntW'(GATE_LAT - 1);

  feeder_state_e state_q, state_d;
  logic [NumShares-1:0][WIDTH-1:0] shares_q, shares_d;
  logic [WIDTH-1:0] mask_or_q, mask_or_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic share_vld_q, share_vld_d, res_valid_q, res_valid_d;
  logic in_ready_q, in_ready_d, rnd_ready_q, rnd_ready_d;

  logic             in_acc, rnd_acc;
  logic [WIDTH-1:0] cache_m1, cache_m2, cache_unused_m2, m1_src, m2_src, a_src, b_src;
  logic             cache_valid;

  assign in_acc  = in_valid & in_ready_q;
  assign rnd_acc = rnd_valid & rnd_ready_q;
  assign cache_unused_m2 = '0;

  mask_rnd_cache #(
    .WIDTH     (WIDTH),
    .REUSE_MAX (REUSE_MAX)
  ) u_cache (
    .clk      (clk),
    .rst      (rst),
    .load     (rnd_acc),
    .rnd_word (rnd_data),
    .consume  (state_q == PRECH),
    .flush    (1'b0),
    .m1       (cache_m1),
    .m2       (cache_m2),
    .valid    (cache_valid)
  );

  // Share sources: fresh RNG word on the RND->DRIVE edge, cached word on the direct
  // IDLE->DRIVE edge; the operand comes straight from the input on that direct path.
  always_comb begin
    m1_src = (state_q == RND) ? rnd_data[WIDTH-1:0]       : cache_m1;
    m2_src = (state_q == RND) ? rnd_data[2*WIDTH-1:WIDTH] : cache_m2;
    a_src  = (state_q == IDLE) ? in_a : a_q;
    b_src  = (state_q == IDLE) ? in_b : b_q;
  end

  // Next-state logic and registered outputs, all decided from the upcoming state.
  always_comb begin
    state_d     = state_q;
    shares_d    = shares_q;
    mask_or_d   = mask_or_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = '0;
    unique case (state_q)
      IDLE: begin
        if (in_acc) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = cache_valid ? DRIVE : RND;
        end
      end
      RND: begin
        if (rnd_acc) state_d = DRIVE;
      end
      DRIVE: begin
        if (cnt_q == HoldLast) state_d = PRECH;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      PRECH: begin
        a_d     = '0;
        b_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // All lanes and shares update on the single DRIVE entry edge, then hold.
    if (state_d != DRIVE) begin
      shares_d  = '0;
      mask_or_d = '0;
    end else if (state_q != DRIVE) begin
      shares_d[ShareA0] = a_src ^ m1_src;
      shares_d[ShareA1] = m1_src;
      shares_d[ShareB0] = b_src ^ m2_src;
      shares_d[ShareB1] = m2_src;
      mask_or_d         = m1_src | m2_src;
    end

    share_vld_d = (state_d == DRIVE);
    res_valid_d = (state_q == DRIVE) && (cnt_q == GateLast);
    in_ready_d  = (state_d == IDLE);
    rnd_ready_d = (state_d == RND);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shares_q    <= '0;
      mask_or_q   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      share_vld_q <= 1'b0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      rnd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shares_q    <= shares_d;
      mask_or_q   <= mask_or_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      share_vld_q <= share_vld_d;
      res_valid_q <= res_valid_d;
      in_ready_q  <= in_ready_d;
      rnd_ready_q <= rnd_ready_d;
    end
  end

  assign a0        = shares_q[ShareA0];
  assign a1        = shares_q[ShareA1];
  assign b0        = shares_q[ShareB0];
  assign b1        = shares_q[ShareB1] | cache_unused_m2;
  assign mask_or   = mask_or_q;
  assign share_vld = share_vld_q;
  assign res_valid = res_valid_q;
  assign in_ready  = in_ready_q;
  assign rnd_ready = rnd_ready_q;

endmodule

// File: tb/tb_masked_and_feeder.sv
// Directed self-checking bench for masked_and_feeder (WIDTH=8, GATE_LAT=2, HOLD=2).
module tb_masked_and_feeder;

  localparam int unsigned GateLat = 2;
  localparam int unsigned Hold    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, rnd_valid, rnd_ready, share_vld, res_valid;
  logic [7:0]  in_a, in_b, a0, a1, b0, b1, mask_or;
  logic [15:0] rnd_data;

  int checks = 0;
  int errors = 0;
  int rnd_hs = 0;

  typedef struct packed {
    logic [7:0] a, b, m1, m2, a0, b0, mor, q;
  } vec_t;
  vec_t vecs [5];

  masked_and_feeder #(
    .WIDTH     (8),
    .GATE_LAT  (GateLat),
    .HOLD      (Hold),
    .REUSE_MAX (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd_data  (rnd_data),
    .a0        (a0),
    .a1        (a1),
    .b0        (b0),
    .b1        (b1),
    .mask_or   (mask_or),
    .share_vld (share_vld),
    .res_valid (res_valid)
  );

  always #5 clk = ~clk;

  // Count RNG handshakes seen by the DUT.
  always @(posedge clk) begin
    if (!rst && rnd_valid && rnd_ready) rnd_hs = rnd_hs + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] share_bus();
    return {24'h0, a0, a1, b0, b1, mask_or};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // One operation; abort_at >= 0 asserts rst after that DRIVE cycle.
  task automatic run_op(input int vi, input int rnd_delay, input int abort_at);
    vec_t v;
    int   n;
    logic stall_bad;
    int   stall_cycles;
    v = vecs[vi];
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    in_a     = v.a;
    in_b     = v.b;
    rnd_data = {v.m2, v.m1};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a     = ~v.a;
    in_b     = ~v.b;
    n = 0;
    stall_bad = 1'b0;
    stall_cycles = 0;
    while (!share_vld && n < rnd_delay + 20) begin
      if (rnd_ready) begin
        if (n < rnd_delay) begin
          stall_cycles++;
          if (share_bus() != 64'h0) stall_bad = 1'b1;
        end
        rnd_valid = (n >= rnd_delay);
      end
      tick();
      n++;
    end
    rnd_valid = 1'b0;
    check("share_vld_rise", share_vld, 1);
    if (rnd_delay > 0) begin
      check("stall_zero", stall_bad, 0);
      check("stall_cycles", stall_cycles, rnd_delay);
    end
    check("gate_q", (a0 ^ a1) & (b0 ^ b1), v.q);
    for (int k = 0; k <= int'(Hold) + 1; k++) begin
      check("res_valid", res_valid, k == int'(GateLat));
      check("share_vld", share_vld, k < int'(Hold));
      check("in_ready_busy", in_ready, k == int'(Hold) + 1);
      if (k < int'(Hold)) check("shares_hold", share_bus(), {24'h0, v.a0, v.m1, v.b0, v.m2, v.mor});
      else                check("precharge", share_bus(), 64'h0);
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out", share_bus(), 64'h0);
        check("abort_flags", {share_vld, res_valid, in_ready, rnd_ready}, 4'b0000);
        tick();
        check("abort_res", res_valid, 0);
        check("abort_rdy", in_ready, 1);
        return;
      end
      if (k < int'(Hold) + 1) tick();
    end
  endtask

  initial begin
    int hs0;
    vecs[0] = '{a:8'hF0, b:8'hCC, m1:8'hA5, m2:8'h3C, a0:8'h55, b0:8'hF0, mor:8'hBD, q:8'hC0};
    vecs[1] = '{a:8'h00, b:8'hFF, m1:8'hFF, m2:8'h00, a0:8'hFF, b0:8'hFF, mor:8'hFF, q:8'h00};
    vecs[2] = '{a:8'h12, b:8'h34, m1:8'h0F, m2:8'hF0, a0:8'h1D, b0:8'hC4, mor:8'hFF, q:8'h10};
    vecs[3] = '{a:8'hFF, b:8'hFF, m1:8'h00, m2:8'h00, a0:8'hFF, b0:8'hFF, mor:8'h00, q:8'hFF};
    vecs[4] = '{a:8'h5A, b:8'hA5, m1:8'h81, m2:8'h18, a0:8'hDB, b0:8'hBD, mor:8'h99, q:8'h00};
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    rnd_valid = 1'b0;
    rnd_data  = '0;

    // Reset for 3 cycles.
    tick();
    tick();
    tick();
    check("rst_shares", share_bus(), 64'h0);
    check("rst_flags", {share_vld, res_valid, in_ready, rnd_ready}, 4'b0000);
    rst = 1'b0;
    check("rst_in_ready_lo", in_ready, 0);
    tick();
    check("rst_in_ready_hi", in_ready, 1);

    // Main vector.
    run_op(0, 0, -1);

    // RNG stalled for 10 cycles.
    do_reset();
    run_op(1, 10, -1);

    // Reset in DRIVE cycle 1, then a clean op.
    do_reset();
    run_op(2, 0, 1);
    run_op(3, 0, -1);
    do_reset();
    run_op(4, 2, -1);

    // Five back-to-back ops with the same RNG word.
    do_reset();
    hs0 = rnd_hs;
    for (int i = 0; i < 5; i++) run_op(0, 0, -1);
`ifdef FEEDER_MASK_REUSE_EN
    check("rnd_handshakes", rnd_hs - hs0, 2);
`else
    check("rnd_handshakes", rnd_hs - hs0, 5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
